// File: rtl/ps2_char_rx_pkg.sv
// Shared types, char/scancode constants and the set-2 make-code map for the PS/2 char receiver.
package ps2_char_rx_pkg;

    localparam int unsigned CODE_W = 6;
    localparam int unsigned BYTE_W = 8;

    typedef logic [CODE_W-1:0] char_t;
    typedef logic [BYTE_W-1:0] scan_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic  hit;
        char_t code;
    } dec_t;

    // Char codes, identical to the renderer's char input encoding
    localparam char_t CH_A = 6'd0;
    localparam char_t CH_B = 6'd1;
    localparam char_t CH_C = 6'd2;
    localparam char_t CH_D = 6'd3;
    localparam char_t CH_E = 6'd4;
    localparam char_t CH_F = 6'd5;
    localparam char_t CH_G = 6'd6;
    localparam char_t CH_H = 6'd7;
    localparam char_t CH_I = 6'd8;
    localparam char_t CH_J = 6'd9;
    localparam char_t CH_K = 6'd10;
    localparam char_t CH_L = 6'd11;
    localparam char_t CH_M = 6'd12;
    localparam char_t CH_N = 6'd13;
    localparam char_t CH_O = 6'd14;
    localparam char_t CH_P = 6'd15;
    localparam char_t CH_Q = 6'd16;
    localparam char_t CH_R = 6'd17;
    localparam char_t CH_S = 6'd18;
    localparam char_t CH_T = 6'd19;
    localparam char_t CH_U = 6'd20;
    localparam char_t CH_V = 6'd21;
    localparam char_t CH_W = 6'd22;
    localparam char_t CH_X = 6'd23;
    localparam char_t CH_Y = 6'd24;
    localparam char_t CH_Z = 6'd25;
    localparam char_t CH_1 = 6'd26;
    localparam char_t CH_2 = 6'd27;
    localparam char_t CH_3 = 6'd28;
    localparam char_t CH_4 = 6'd29;
    localparam char_t CH_5 = 6'd30;
    localparam char_t CH_6 = 6'd31;
    localparam char_t CH_7 = 6'd32;
    localparam char_t CH_8 = 6'd33;
    localparam char_t CH_9 = 6'd34;
    localparam char_t CH_0 = 6'd35;

    localparam scan_t SC_BREAK = 8'hF0;
    localparam scan_t SC_EXT   = 8'hE0;

    localparam scan_t SC_A = 8'h1C;
    localparam scan_t SC_B = 8'h32;
    localparam scan_t SC_C = 8'h21;
    localparam scan_t SC_D = 8'h23;
    localparam scan_t SC_E = 8'h24;
    localparam scan_t SC_F = 8'h2B;
    localparam scan_t SC_G = 8'h34;
    localparam scan_t SC_H = 8'h33;
    localparam scan_t SC_I = 8'h43;
    localparam scan_t SC_J = 8'h3B;
    localparam scan_t SC_K = 8'h42;
    localparam scan_t SC_L = 8'h4B;
    localparam scan_t SC_M = 8'h3A;
    localparam scan_t SC_N = 8'h31;
    localparam scan_t SC_O = 8'h44;
    localparam scan_t SC_P = 8'h4D;
    localparam scan_t SC_Q = 8'h15;
    localparam scan_t SC_R = 8'h2D;
    localparam scan_t SC_S = 8'h1B;
    localparam scan_t SC_T = 8'h2C;
    localparam scan_t SC_U = 8'h3C;
    localparam scan_t SC_V = 8'h2A;
    localparam scan_t SC_W = 8'h1D;
    localparam scan_t SC_X = 8'h22;
    localparam scan_t SC_Y = 8'h35;
    localparam scan_t SC_Z = 8'h1A;
    localparam scan_t SC_1 = 8'h16;
    localparam scan_t SC_2 = 8'h1E;
    localparam scan_t SC_3 = 8'h26;
    localparam scan_t SC_4 = 8'h25;
    localparam scan_t SC_5 = 8'h2E;
    localparam scan_t SC_6 = 8'h36;
    localparam scan_t SC_7 = 8'h3D;
    localparam scan_t SC_8 = 8'h3E;
    localparam scan_t SC_9 = 8'h46;
    localparam scan_t SC_0 = 8'h45;

    // Set-2 make code to char code; hit=0 for anything outside A-Z / 0-9
    function automatic dec_t decode_make(input scan_t sc);
        dec_t d;
        d.hit  = 1'b1;
        d.code = '0;
        case (sc)
            SC_A: d.code = CH_A;
            SC_B: d.code = CH_B;
            SC_C: d.code = CH_C;
            SC_D: d.code = CH_D;
            SC_E: d.code = CH_E;
            SC_F: d.code = CH_F;
            SC_G: d.code = CH_G;
            SC_H: d.code = CH_H;
            SC_I: d.code = CH_I;
            SC_J: d.code = CH_J;
            SC_K: d.code = CH_K;
            SC_L: d.code = CH_L;
            SC_M: d.code = CH_M;
            SC_N: d.code = CH_N;
            SC_O: d.code = CH_O;
            SC_P: d.code = CH_P;
            SC_Q: d.code = CH_Q;
            SC_R: d.code = CH_R;
            SC_S: d.code = CH_S;
            SC_T: d.code = CH_T;
            SC_U: d.code = CH_U;
            SC_V: d.code = CH_V;
            SC_W: d.code = CH_W;
            SC_X: d.code = CH_X;
            SC_Y: d.code = CH_Y;
            SC_Z: d.code = CH_Z;
            SC_1: d.code = CH_1;
            SC_2: d.code = CH_2;
            SC_3: d.code = CH_3;
            SC_4: d.code = CH_4;
            SC_5: d.code = CH_5;
            SC_6: d.code = CH_6;
            SC_7: d.code = CH_7;
            SC_8: d.code = CH_8;
            SC_9: d.code = CH_9;
            SC_0: d.code = CH_0;
            default: d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_char_rx_if.sv
// Char stream from the PS/2 receiver to the renderer, plus error/overflow pulses.
interface ps2_char_rx_if;
    import ps2_char_rx_pkg::*;

    logic  char_valid;
    char_t char_code;
    logic  char_ready;
    logic  frame_err;
    logic  overflow;

    modport master (
        output char_valid,
        output char_code,
        output frame_err,
        output overflow,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_code,
        input  frame_err,
        input  overflow,
        output char_ready
    );

endinterface

// File: rtl/ps2_char_rx_char_fifo.sv
// First-word fall-through sync FIFO with registered head and a drop/overflow pulse.
module char_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             full_c, pop_do_c, push_do_c, ovf_c;

    always_comb begin
        full_c    = (count == CW'(DEPTH));
        pop_do_c  = pop && (count != '0);
        push_do_c = push && (!full_c || pop_do_c);
        ovf_c     = push && full_c && !pop_do_c;
        wr_nxt    = wr_ptr + AW'(push_do_c);
        rd_nxt    = rd_ptr + AW'(pop_do_c);
        count_nxt = count + CW'(push_do_c) - CW'(pop_do_c);
        // New head bypasses memory when it lands in the slot being read next
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push_do_c && (rd_nxt == wr_ptr)) begin
            head_nxt = wdata;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_do_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            rdata    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            count    <= count_nxt;
            valid    <= (count_nxt != '0);
            rdata    <= head_nxt;
            overflow <= ovf_c;
        end
    end

endmodule

// File: rtl/ps2_char_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM with timeout, set-2 decode, char FIFO.
module ps2_char_rx
    import ps2_char_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 200000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_char_rx_if.master     chr
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    localparam int unsigned BCW = 3;

    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           filt_clk;
    logic [FCW-1:0] fcnt;
    logic           strobe_c, timeout_c;
    logic [TCW-1:0] tcnt;

    rx_state_e      state, state_nxt;
    scan_t          shift_q, shift_nxt;
    logic [BCW-1:0] bitcnt, bitcnt_nxt;
    logic           par_q, par_nxt;
    logic           byte_done_q, byte_done_nxt;
    logic           frame_err_q, frame_err_nxt;

    logic           brk, ext, push_q;
    char_t          push_code;
    dec_t           dec_c;

    // Two-flop synchronisers; idle-high reset avoids a false edge on release
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        strobe_c  = filt_clk && !clk_s2 && (fcnt == FCW'(FILTER_LEN - 1));
        timeout_c = (state != ST_IDLE) && !strobe_c && (tcnt == TCW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            filt_clk <= 1'b1;
            fcnt     <= '0;
        end else if (clk_s2 == filt_clk) begin
            fcnt <= '0;
        end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            fcnt     <= '0;
        end else begin
            fcnt <= fcnt + FCW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tcnt <= '0;
        end else if ((state == ST_IDLE) || strobe_c) begin
            tcnt <= '0;
        end else if (tcnt != TCW'(TIMEOUT - 1)) begin
            tcnt <= tcnt + TCW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            bitcnt      <= '0;
            par_q       <= 1'b0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_q     <= shift_nxt;
            bitcnt      <= bitcnt_nxt;
            par_q       <= par_nxt;
            byte_done_q <= byte_done_nxt;
            frame_err_q <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_q;
        bitcnt_nxt    = bitcnt;
        par_nxt       = par_q;
        byte_done_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        if (timeout_c) begin
            state_nxt     = ST_IDLE;
            frame_err_nxt = 1'b1;
        end else if (strobe_c) begin
            case (state)
                ST_IDLE: begin
                    if (!data_s2) begin
                        state_nxt  = ST_DATA;
                        bitcnt_nxt = '0;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt  = {data_s2, shift_q[BYTE_W-1:1]};
                    bitcnt_nxt = bitcnt + BCW'(1);
                    if (bitcnt == BCW'(BYTE_W - 1)) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_nxt   = data_s2;
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s2 && (^{shift_q, par_q})) begin
                        byte_done_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign dec_c = decode_make(shift_q);

    // Break/extended prefixes swallow the next byte; make codes become pushes
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            brk       <= 1'b0;
            ext       <= 1'b0;
            push_q    <= 1'b0;
            push_code <= '0;
        end else begin
            push_q <= 1'b0;
            if (byte_done_q) begin
                if (shift_q == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (shift_q == SC_EXT) begin
                    ext <= 1'b1;
                end else if (brk || ext) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else begin
                    push_q    <= dec_c.hit;
                    push_code <= dec_c.code;
                end
            end
        end
    end

    assign chr.frame_err = frame_err_q;

    char_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .push     (push_q),
        .wdata    (push_code),
        .pop      (chr.char_ready),
        .valid    (chr.char_valid),
        .rdata    (chr.char_code),
        .overflow (chr.overflow)
    );

endmodule
